// File: rtl/hyperbus_pkg.sv
// hyperbus_pkg: shared FSM states, command/address layout and transfer descriptor
package hyperbus_pkg;
  localparam int CsW = 4;
  typedef enum logic [2:0] {IDLE, CA, WAIT_LAT, WRITE, READ, DRAIN, HOLD, RECOVERY} state_t;
  typedef struct packed {
    logic        rw_n;
    logic        as_reg;
    logic        linear;
    logic [28:0] addr_hi;
    logic [12:0] rsvd;
    logic [2:0]  addr_lo;
  } ca_t;
  typedef struct packed {
    logic           write;
    logic           reg_space;
    logic           linear;
    logic [31:0]    addr;
    logic [15:0]    len;
    logic [CsW-1:0] cs;
  } hyper_tf_t;
  function automatic ca_t build_ca(input logic write, input logic reg_space, input logic linear,
                                   input logic [31:0] addr);
    return {~write, reg_space, linear, addr[31:3], 13'd0, addr[2:0]};
  endfunction
endpackage

// File: rtl/hyperbus_phy_ctrl.sv
// hyperbus_phy_ctrl: transfer sequencer driving hyperbus_trx control inputs
module hyperbus_phy_ctrl
  import hyperbus_pkg::*;
#(
  parameter int NumChips     = 2,
  parameter int DrainTimeout = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [3:0]                  cfg_latency_i,
  input  logic                        cfg_fixed_lat_i,
  input  logic [3:0]                  cfg_t_rwr_i,
  input  logic                        tf_valid_i,
  output logic                        tf_ready_o,
  input  logic                        tf_write_i,
  input  logic                        tf_reg_i,
  input  logic                        tf_linear_i,
  input  logic [31:0]                 tf_addr_i,
  input  logic [15:0]                 tf_len_i,
  input  logic [$clog2(NumChips)-1:0] tf_cs_i,
  input  logic [15:0]                 wdata_i,
  input  logic [1:0]                  wstrb_i,
  input  logic                        wvalid_i,
  output logic                        wready_o,
  output logic [15:0]                 rdata_o,
  output logic                        rvalid_o,
  output logic                        rlast_o,
  output logic                        resp_valid_o,
  output logic                        resp_error_o,
  output logic                        trx_clk_ena_o,
  output logic [NumChips-1:0]         trx_cs_o,
  output logic                        trx_cs_ena_o,
  output logic                        trx_rwds_sample_ena_o,
  output logic [15:0]                 trx_tx_data_o,
  output logic                        trx_tx_data_oe_o,
  output logic [1:0]                  trx_tx_rwds_o,
  output logic                        trx_tx_rwds_oe_o,
  output logic                        trx_rx_clk_ena_o,
  output logic                        trx_rx_ready_o,
  input  logic                        trx_rwds_sample_i,
  input  logic [15:0]                 trx_rx_data_i,
  input  logic                        trx_rx_valid_i
);
  state_t    state, state_n;
  hyper_tf_t tf_q;
  ca_t       ca;
  logic [15:0] cnt, cnt_ld;
  logic [16:0] rcnt, rcnt_n;
  logic [4:0]  lat_tot;
  logic        cnt_z, rx_acc, rx_done, err_q, first_q;
  assign ca      = build_ca(tf_q.write, tf_q.reg_space, tf_q.linear, tf_q.addr);
  assign cnt_z   = cnt == '0;
  assign rx_acc  = (state == READ || state == DRAIN) && trx_rx_valid_i && rcnt <= {1'b0, tf_q.len};
  assign rcnt_n  = rcnt + 17'(rx_acc);
  assign rx_done = rcnt_n == {1'b0, tf_q.len} + 17'd1;
  assign lat_tot = (trx_rwds_sample_i | cfg_fixed_lat_i) ? {cfg_latency_i, 1'b0} : {1'b0, cfg_latency_i};
  always_ff @(posedge clk_i) state <= !rst_ni ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = tf_valid_i ? CA : IDLE;
      CA:       if (cnt_z) state_n = (tf_q.write && tf_q.reg_space) ? WRITE : WAIT_LAT;
      WAIT_LAT: if (cnt_z) state_n = tf_q.write ? WRITE : READ;
      WRITE:    if (cnt_z) state_n = HOLD;
      READ:     if (cnt_z) state_n = DRAIN;
      DRAIN:    if (rx_done || cnt_z) state_n = HOLD;
      HOLD:     state_n = RECOVERY;
      RECOVERY: if (cnt_z) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // one downcounter, reloaded with the length of whichever phase is entered
  always_comb
    cnt_ld = state_n == CA ? 16'd2 :
             state_n == WAIT_LAT ? 16'(lat_tot) - 16'd2 :
             (state_n == WRITE || state_n == READ) ? tf_q.len :
             state_n == DRAIN ? 16'(DrainTimeout - 1) :
             (state_n == RECOVERY && cfg_t_rwr_i != 4'd0) ? 16'(cfg_t_rwr_i - 4'd1) : 16'd0;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt     <= '0;
      rcnt    <= '0;
      tf_q    <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      cnt     <= state_n == state ? cnt - 16'd1 : cnt_ld;
      rcnt    <= state == IDLE ? '0 : rcnt_n;
      first_q <= state == HOLD;
      if (state == IDLE && tf_valid_i) begin
        tf_q  <= '{write: tf_write_i, reg_space: tf_reg_i, linear: tf_linear_i,
                   addr: tf_addr_i, len: tf_len_i, cs: CsW'(tf_cs_i)};
        err_q <= 1'b0;
      end else if ((state == WRITE && !wvalid_i) || (state == DRAIN && cnt_z && !rx_done)) begin
        err_q <= 1'b1;
      end
    end
  end
  always_comb begin
    tf_ready_o            = state == IDLE;
    trx_cs_ena_o          = state inside {CA, WAIT_LAT, WRITE, READ, DRAIN, HOLD};
    trx_clk_ena_o         = state inside {CA, WAIT_LAT, WRITE, READ};
    trx_cs_o              = trx_cs_ena_o ? NumChips'(1) << tf_q.cs : '0;
    trx_rwds_sample_ena_o = state == CA && cnt == 16'd1;
    trx_tx_data_oe_o      = state == CA || state == WRITE;
    trx_tx_data_o         = state == CA ? (cnt == 16'd2 ? ca[47:32] : cnt == 16'd1 ? ca[31:16] : ca[15:0]) :
                            state == WRITE ? wdata_i : '0;
    trx_tx_rwds_oe_o      = state == WRITE && !tf_q.reg_space;
    trx_tx_rwds_o         = state == WRITE ? (wvalid_i ? ~wstrb_i : 2'b11) : '0;
    trx_rx_clk_ena_o      = state == READ || state == DRAIN;
    wready_o              = state == WRITE;
    rvalid_o              = rx_acc;
    rdata_o               = rx_acc ? trx_rx_data_i : '0;
    rlast_o               = rx_acc && rcnt == {1'b0, tf_q.len};
    resp_valid_o          = state == RECOVERY && first_q;
    resp_error_o          = state == RECOVERY && first_q && err_q;
  end
  assign trx_rx_ready_o = 1'b1;
endmodule

// File: doc/hyperbus_phy_ctrl.md
Name: hyperbus_phy_ctrl

Overview:
System-synchronous control FSM that sits directly upstream of hyperbus_trx and drives its control inputs. It accepts one transfer descriptor at a time and issues the 48-bit command/address (CA) phase. It then applies initial latency (single or doubled, based on the sampled RWDS), streams write words or collects read words, and finishes with CS hold and read-write recovery. Transfer, write-data, read-data and response interfaces face the HyperBus controller front end.

Parameters:
NumChips, 2, number of chip selects; width of cs_i on hyperbus_trx.
DrainTimeout, 16, maximum cycles to wait for outstanding read words after the last clock.

Ports:
clk_i  in  1  system clock (clk_0 domain of trx)
rst_ni  in  1  synchronous active-low reset
cfg_latency_i  in  4  initial latency in CK cycles (legal 3..7)
cfg_fixed_lat_i  in  1  always use doubled latency
cfg_t_rwr_i  in  4  CS-high recovery cycles (min 1)
tf_valid_i  in  1  transfer request valid
tf_ready_o  out  1  transfer accepted (IDLE only)
tf_write_i  in  1  1=write, 0=read
tf_reg_i  in  1  address space: 1=register, 0=memory
tf_linear_i  in  1  1=linear burst, 0=wrapped
tf_addr_i  in  32  16-bit word address
tf_len_i  in  16  words minus one
tf_cs_i  in  $clog2(NumChips)  target chip index
wdata_i  in  16  write word; [15:8] sent on first edge
wstrb_i  in  2  byte enables ([1] for [15:8])
wvalid_i  in  1  write word valid
wready_o  out  1  write word taken
rdata_o  out  16  read word
rvalid_o  out  1  read word valid, no backpressure
rlast_o  out  1  final read word
resp_valid_o  out  1  one-cycle done pulse
resp_error_o  out  1  write underrun or read timeout
trx_clk_ena_o, trx_cs_o[NumChips], trx_cs_ena_o, trx_rwds_sample_ena_o, trx_tx_data_o[16], trx_tx_data_oe_o, trx_tx_rwds_o[2], trx_tx_rwds_oe_o, trx_rx_clk_ena_o, trx_rx_ready_o  out  as named  to hyperbus_trx
trx_rwds_sample_i  in  1, trx_rx_data_i  in  16, trx_rx_valid_i  in  1  from hyperbus_trx

Behaviour:
- Reset (rst_ni low at posedge): state IDLE; all outputs 0, except tf_ready_o=1 and trx_rx_ready_o=1 (constant). Reset mid-transfer aborts immediately: CS released next cycle, no response pulse.
- States: IDLE -> CA -> (WAIT_LAT) -> WRITE | READ -> DRAIN (read only) -> HOLD -> RECOVERY -> IDLE.
- IDLE: on tf_valid_i, latch descriptor, set cs one-hot = 1<<tf_cs_i, go CA.
- CA: exactly 3 cycles with cs_ena=1, clk_ena=1, data_oe=1, tx_data = CA[47:32], [31:16], [15:0]. CA[47]=~write, [46]=reg, [45]=linear, [44:16]=addr[31:3], [15:3]=0, [2:0]=addr[2:0]. rwds_sample_ena=1 in CA cycle 2. Register write: go to WRITE after CA3 (zero latency), otherwise go to WAIT_LAT.
- WAIT_LAT: total = 2*cfg_latency_i if (trx_rwds_sample_i | cfg_fixed_lat_i), else cfg_latency_i. State lasts total-1 cycles (CA3 counts as the first latency cycle). clk_ena=1, data_oe=0.
- WRITE: len+1 cycles. clk_ena=1, data_oe=1, rwds_oe=1 (register space: rwds_oe=0). Each cycle wready_o=1 and tx_rwds={~wstrb[1],~wstrb[0]}. If wvalid_i=0 in any WRITE cycle, that word is sent masked (tx_rwds=2'b11) and the error flag is set; the transfer continues.
- READ: len+1 cycles with clk_ena=1 and rx_clk_ena=1. Receive counter increments on each trx_rx_valid_i; each received word is forwarded combinationally to rdata_o/rvalid_o. rlast_o=1 when received count == len.
- DRAIN: clk_ena=0, rx_clk_ena=1. Exit when count reaches len+1. After DrainTimeout cycles, set error and exit. Excess rx words outside READ/DRAIN are dropped.
- HOLD: 1 cycle, cs_ena=1, clk_ena=0 (t_CSH).
- RECOVERY: cs_ena=0 for cfg_t_rwr_i cycles (0 treated as 1). resp_valid_o pulses in the first cycle, with resp_error_o.
- tf_ready_o=1 only in IDLE. Back-to-back requests always get at least t_rwr CS-high cycles.
- Counters: 16-bit word counters; len=16'hFFFF gives 65536 words with no wrap.

Decomposition:
- hyperbus_pkg gets: state enum, ca_t packed struct (47:0) with function build_ca(write, reg, linear, addr), and the hyper_tf_t descriptor struct.
- No sub-module. The latency/recovery downcounter is shared across states; the receive counter is separate.

Test Plan:
- Register write, addr 0x0000_0800, len 0, wdata 0x8F1F, strb 2'b11 -> CA 0x6000,0x0100,0x0000; one WRITE cycle with 0x8F1F and rwds_oe=0; resp error=0.
- Memory read, lat 6, rwds sample 0, len 3 -> exactly 5 WAIT cycles, 4 READ clocks, 4 rvalid with rlast on the 4th.
- Same read with rwds sample 1 -> 11 WAIT cycles; cfg_fixed_lat_i=1 with sample 0 -> also 11.
- Memory write len 3, wvalid low on word 2 -> word 2 tx_rwds=2'b11; resp_error=1; CS high for cfg_t_rwr_i=2 cycles.
- Read len 1 where only 1 rx word arrives -> DRAIN times out after 16 cycles; resp_error=1; FSM back in IDLE.
- Assert rst_ni low during WRITE -> next cycle trx_cs_ena_o=0, clk_ena=0, tf_ready_o=1, no resp pulse.
